// File: rtl/dp_arbiter.sv
// dp_arbiter: round-robin owner of a shared dot_product engine.
// Latches the winner's operands, clears and runs the engine, returns one result.
module dp_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int VECTOR_LEN = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req,
    input  logic [NUM_REQ-1:0][VECTOR_LEN-1:0][31:0] req_vec1,
    input  logic [NUM_REQ-1:0][VECTOR_LEN-1:0][31:0] req_vec2,
    output logic [NUM_REQ-1:0]                       gnt,
    output logic [NUM_REQ-1:0]                       rsp_valid,
    output logic [31:0]                              rsp_result,
    output logic                                     rsp_error,
    output logic                                     busy,
    output logic                                     eng_rst,
    output logic [VECTOR_LEN-1:0][31:0]              eng_vec1,
    output logic [VECTOR_LEN-1:0][31:0]              eng_vec2,
    input  logic                                     eng_done,
    input  logic [31:0]                              eng_result
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        RESP
    } state_e;

    state_e state_q, state_d;

    logic [IW-1:0]                 win_q, win_d;
    logic [IW-1:0]                 last_q, last_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [NUM_REQ-1:0]            gnt_q, gnt_d;
    logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [31:0]                   rsp_result_q, rsp_result_d;
    logic                          rsp_error_q, rsp_error_d;
    logic                          busy_q, busy_d;
    logic                          eng_rst_q, eng_rst_d;
    logic [VECTOR_LEN-1:0][31:0]   vec1_q, vec1_d;
    logic [VECTOR_LEN-1:0][31:0]   vec2_q, vec2_d;

    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    logic          last_cnt;

    assign last_cnt = (cnt_q == CW'(TIMEOUT - 1));

    // Search upward from last+1 so the previous owner is considered last.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last_q) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (found) state_d = CLEAR;
            CLEAR:   state_d = RUN;
            RUN:     if (eng_done || last_cnt) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_d        = win_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        vec1_d       = vec1_q;
        vec2_d       = vec2_q;
        eng_rst_d    = (state_d != RUN);
        busy_d       = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    win_d       = pick;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    vec1_d      = req_vec1[pick];
                    vec2_d      = req_vec2[pick];
                end
            end
            CLEAR: cnt_d = '0;
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                // Done takes priority over the watchdog on the final count.
                if (eng_done) begin
                    rsp_result_d       = eng_result;
                    rsp_error_d        = 1'b0;
                    rsp_valid_d[win_q] = 1'b1;
                end else if (last_cnt) begin
                    rsp_result_d       = '0;
                    rsp_error_d        = 1'b1;
                    rsp_valid_d[win_q] = 1'b1;
                end
            end
            RESP: begin
                last_d = win_q;
                gnt_d  = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q        <= '0;
            last_q       <= IW'(NUM_REQ - 1);
            cnt_q        <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b0;
            busy_q       <= 1'b0;
            eng_rst_q    <= 1'b1;
            vec1_q       <= '0;
            vec2_q       <= '0;
        end else begin
            win_q        <= win_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            busy_q       <= busy_d;
            eng_rst_q    <= eng_rst_d;
            vec1_q       <= vec1_d;
            vec2_q       <= vec2_d;
        end
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign busy       = busy_q;
    assign eng_rst    = eng_rst_q;
    assign eng_vec1   = vec1_q;
    assign eng_vec2   = vec2_q;

endmodule

// File: tb/tb_dp_arbiter.sv
// tb_dp_arbiter: directed and random transactions against a
// transaction-level round-robin/latency model and a behavioural engine.
module tb_dp_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int VECTOR_LEN = 4;
    localparam int TIMEOUT    = 64;

    typedef logic [VECTOR_LEN-1:0][31:0] vec_t;

    logic                                     clk = 1'b0;
    logic                                     rst;
    logic [NUM_REQ-1:0]                       req;
    logic [NUM_REQ-1:0][VECTOR_LEN-1:0][31:0] req_vec1;
    logic [NUM_REQ-1:0][VECTOR_LEN-1:0][31:0] req_vec2;
    logic [NUM_REQ-1:0]                       gnt;
    logic [NUM_REQ-1:0]                       rsp_valid;
    logic [31:0]                              rsp_result;
    logic                                     rsp_error;
    logic                                     busy;
    logic                                     eng_rst;
    vec_t                                     eng_vec1;
    vec_t                                     eng_vec2;
    logic                                     eng_done;
    logic [31:0]                              eng_result;

    int vectors     = 0;
    int miscompares = 0;
    int last_m      = NUM_REQ - 1;
    int done_at     = -1;
    int eng_cnt     = 0;
    bit force_done  = 1'b0;

    dp_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .VECTOR_LEN (VECTOR_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_vec1   (req_vec1),
        .req_vec2   (req_vec2),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .busy       (busy),
        .eng_rst    (eng_rst),
        .eng_vec1   (eng_vec1),
        .eng_vec2   (eng_vec2),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    always #5 clk = ~clk;

    // Engine: counts RUN cycles since clear, raises done after done_at.
    always_ff @(posedge clk) begin
        if (eng_rst) eng_cnt <= 0;
        else         eng_cnt <= eng_cnt + 1;
    end

    assign eng_done = force_done | (!eng_rst && (eng_cnt == done_at));

    function automatic logic [31:0] dot(input vec_t a, input vec_t b);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < VECTOR_LEN; i++) s = s + a[i] * b[i];
        return s;
    endfunction

    always_comb eng_result = dot(eng_vec1, eng_vec2);

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_vecs(input int k);
        for (int i = 0; i < VECTOR_LEN; i++) begin
            req_vec1[k][i] = $urandom;
            req_vec2[k][i] = $urandom;
        end
    endtask

    // One full grant: DUT in IDLE, req already set; returns in the next IDLE.
    task automatic serve(input int w, input int d, input bit err, input bit stale,
                         input int raise_at, input logic [NUM_REQ-1:0] raise_mask,
                         input bit rereq);
        logic [NUM_REQ-1:0] oh;
        logic [NUM_REQ-1:0] zero;
        logic [31:0]        exp_res;
        int                 lat;
        oh      = '0;
        zero    = '0;
        oh[w]   = 1'b1;
        exp_res = err ? 32'd0 : dot(req_vec1[w], req_vec2[w]);
        done_at = err ? -1 : d;
        lat     = err ? TIMEOUT - 1 : d;
        tick();
        check("grant", 256'(gnt), 256'(oh));
        check("clear_busy_rst", 256'({busy, eng_rst}), 256'(2'b11));
        check("eng_vec1", 256'(eng_vec1), 256'(req_vec1[w]));
        check("eng_vec2", 256'(eng_vec2), 256'(req_vec2[w]));
        force_done = stale;
        tick();
        force_done = 1'b0;
        for (int i = 0; i < lat; i++) begin
            if (i == raise_at) req = req | raise_mask;
            check("run", 256'({gnt, rsp_valid, eng_rst}), 256'({oh, zero, 1'b0}));
            tick();
        end
        tick();
        check("rsp_valid", 256'(rsp_valid), 256'(oh));
        check("rsp_result", 256'(rsp_result), 256'(exp_res));
        check("rsp_error", 256'(rsp_error), 256'(err));
        check("resp_gnt_busy", 256'({gnt, busy}), 256'({oh, 1'b1}));
        req[w] = 1'b0;
        tick();
        check("idle", 256'({gnt, rsp_valid, busy, eng_rst}),
              256'({zero, zero, 1'b0, 1'b1}));
        check("held_result", 256'(rsp_result), 256'(exp_res));
        last_m = w;
        if (rereq) req[w] = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  d;
        bit  e;
        bit  st;
        int  kk;
        rst      = 1'b0;
        req      = '0;
        req_vec1 = '0;
        req_vec2 = '0;
        tick();
        tick();
        check("reset_outs", 256'({gnt, rsp_valid, rsp_error, busy, eng_rst}),
              256'({8'h00, 1'b0, 1'b0, 1'b1}));
        check("reset_result", 256'(rsp_result), 256'(0));
        check("reset_vec", 256'({eng_vec1, eng_vec2}), 256'(0));
        rst = 1'b1;
        for (int k = 0; k < NUM_REQ; k++) rand_vecs(k);

        // Round-robin with all four requesting continuously.
        req = 4'b1111;
        serve(0, 1, 1'b0, 1'b0, -1, '0, 1'b1);
        serve(1, 0, 1'b0, 1'b0, -1, '0, 1'b1);
        serve(2, 2, 1'b0, 1'b0, -1, '0, 1'b1);
        serve(3, 1, 1'b0, 1'b0, -1, '0, 1'b1);
        serve(0, 3, 1'b0, 1'b0, -1, '0, 1'b0);
        req = '0;
        tick();

        // Single request with known operands.
        req_vec1[2] = {32'd4, 32'd3, 32'd2, 32'd1};
        req_vec2[2] = {32'd8, 32'd7, 32'd6, 32'd5};
        req = 4'b0100;
        serve(2, 4, 1'b0, 1'b0, -1, '0, 1'b0);
        check("single_70", 256'(rsp_result), 256'(32'd70));

        // From last=2: 1011 grants 3 then 0.
        req = 4'b1011;
        serve(3, 2, 1'b0, 1'b0, -1, '0, 1'b0);
        serve(0, 1, 1'b0, 1'b0, -1, '0, 1'b0);
        serve(1, 0, 1'b0, 1'b0, -1, '0, 1'b0);

        // Watchdog abort, then a normal grant.
        req = 4'b0010;
        serve(1, 0, 1'b1, 1'b0, -1, '0, 1'b0);
        req = 4'b1000;
        serve(3, 3, 1'b0, 1'b0, -1, '0, 1'b0);

        // Done on the final RUN count; stale done during CLEAR.
        req = 4'b0100;
        serve(2, TIMEOUT - 1, 1'b0, 1'b0, -1, '0, 1'b0);
        req = 4'b0001;
        serve(0, 2, 1'b0, 1'b1, -1, '0, 1'b0);

        // Requester 1 arrives during requester 0's RUN.
        req = 4'b0001;
        serve(0, 5, 1'b0, 1'b0, 2, 4'b0010, 1'b0);
        serve(1, 1, 1'b0, 1'b0, -1, '0, 1'b0);

        // Reset in the middle of a run.
        req     = 4'b0100;
        done_at = -1;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("midrst_outs", 256'({gnt, rsp_valid, rsp_error, busy, eng_rst}),
              256'({8'h00, 1'b0, 1'b0, 1'b1}));
        check("midrst_result", 256'(rsp_result), 256'(0));
        check("midrst_vec", 256'({eng_vec1, eng_vec2}), 256'(0));
        @(posedge clk);
        #1;
        rst    = 1'b1;
        last_m = NUM_REQ - 1;
        req    = 4'b0011;
        serve(0, 2, 1'b0, 1'b0, -1, '0, 1'b0);
        serve(1, 1, 1'b0, 1'b0, -1, '0, 1'b0);

        // Random traffic against the round-robin model.
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (!req[k]) rand_vecs(k);
            req = req | NUM_REQ'($urandom);
            if (req == '0) begin
                kk = $urandom_range(0, NUM_REQ - 1);
                req[kk] = 1'b1;
            end
            d  = $urandom_range(0, 10);
            e  = ($urandom_range(0, 7) == 0);
            st = 1'($urandom_range(0, 1));
            serve(rr_pick(req, last_m), d, e, st, -1, '0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
